// File: rtl/design_select_ctrl_pkg.sv
// Shared definitions for the design select controller: register map,
// FSM state encoding and CTRL field layout.
package design_select_ctrl_pkg;

  localparam int unsigned WB_DW       = 32;
  localparam int unsigned SEL_W       = 8;
  localparam int unsigned RSTLEN_W    = 8;
  localparam int unsigned CTRL_EN_BIT = 8;

  // Word index taken from adr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CLKDIV = 2'd1;
  localparam logic [1:0] REG_RSTLEN = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  function automatic logic [1:0] reg_index(input logic [WB_DW-1:0] adr);
    return adr[3:2];
  endfunction

endpackage

// File: rtl/design_clk_div.sv
// Programmable toggle divider: period 2*(div+1) clocks, sync clear,
// and a strobe marking the cycle whose closing edge raises clk_o.
module design_clk_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             clk_o,
  output logic             rise_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             wrap_c;

  assign wrap_c = (cnt_q == div);
  assign rise_c = ~clr & wrap_c & ~clk_q;
  assign clk_o  = clk_q;

  always_comb begin
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (clr) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (wrap_c) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

endmodule

// File: rtl/design_select_ctrl.sv
// Wishbone-controlled design multiplexer: selects one design, routes its
// pads, divides the design clock and sequences per-design resets.
module design_select_ctrl
  import design_select_ctrl_pkg::*;
#(
  parameter int unsigned N_DESIGNS   = 16,
  parameter int unsigned IO_W        = 28,
  parameter int unsigned DIV_W       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned RST_DEFAULT = 4
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic [31:0]               wbs_dat_o,
  output logic                      wbs_ack_o,
  input  logic [IO_W-1:0]           io_in,
  output logic [IO_W-1:0]           dsi_all,
  input  logic [N_DESIGNS*IO_W-1:0] dso_bus,
  input  logic [N_DESIGNS*IO_W-1:0] oeb_bus,
  output logic [IO_W-1:0]           io_out,
  output logic [IO_W-1:0]           io_oeb,
  output logic [N_DESIGNS-1:0]      rst_o,
  output logic                      design_clk_o
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    active_q, active_d;
  logic                en_q, en_d;
  logic                err_q, err_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [RSTLEN_W-1:0] rstlen_q, rstlen_d;
  logic [RSTLEN_W-1:0] hold_q, hold_d;
  logic                drain_q, drain_d;
  logic                ack_q, ack_d;
  logic [WB_DW-1:0]    dat_q, dat_d;

  logic                req_c, wr_c, ctrl_ok_c, div_wr_c;
  logic [1:0]          idx_c;
  logic [SEL_W-1:0]    new_sel_c;
  logic                new_en_c, sel_ok_c, rise_c, hold_done_c;
  logic [RSTLEN_W-1:0] rstlen_eff_c;
  logic [WB_DW-1:0]    rdata_c;
  logic                unused_bits_c;

  assign dsi_all       = io_in;
  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign unused_bits_c = ^{wbs_adr_i[1:0], wbs_dat_i};

  // Bus decode; a pending ack blocks the next request so strobes ack alternately
  assign idx_c     = reg_index(wbs_adr_i);
  assign req_c     = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_c      = req_c & wbs_we_i;
  assign new_sel_c = wbs_dat_i[SEL_W-1:0];
  assign new_en_c  = wbs_dat_i[CTRL_EN_BIT];
  assign sel_ok_c  = (32'(new_sel_c) < 32'(N_DESIGNS));
  assign ctrl_ok_c = wr_c & (idx_c == REG_CTRL) & sel_ok_c;
  assign div_wr_c  = wr_c & (idx_c == REG_CLKDIV);

  assign rstlen_eff_c = (rstlen_q == '0) ? RSTLEN_W'(1) : rstlen_q;
  assign hold_done_c  = ({1'b0, hold_q} + 9'd1) >= {1'b0, rstlen_eff_c};

  design_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (div_wr_c),
    .div    (div_q),
    .clk_o  (design_clk_o),
    .rise_c (rise_c)
  );

  always_comb begin
    case (idx_c)
      REG_CTRL:   rdata_c = 32'({en_q, sel_q});
      REG_CLKDIV: rdata_c = 32'(div_q);
      REG_RSTLEN: rdata_c = 32'(rstlen_q);
      default:    rdata_c = 32'({err_q, active_q, state_q});
    endcase
  end

  // Register file and bus response
  always_comb begin
    sel_d    = sel_q;
    en_d     = en_q;
    err_d    = err_q;
    div_d    = div_q;
    rstlen_d = rstlen_q;
    ack_d    = req_c;
    dat_d    = '0;
    if (req_c && !wbs_we_i) dat_d = rdata_c;
    if (wr_c) begin
      case (idx_c)
        REG_CTRL: begin
          if (sel_ok_c) begin
            sel_d = new_sel_c;
            en_d  = new_en_c;
          end else begin
            err_d = 1'b1;
          end
        end
        REG_CLKDIV: div_d    = wbs_dat_i[DIV_W-1:0];
        REG_RSTLEN: rstlen_d = wbs_dat_i[RSTLEN_W-1:0];
        default:    err_d    = 1'b0;
      endcase
    end
  end

  // Reset sequencer; CTRL writes override the natural progression
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    drain_d  = drain_q;
    hold_d   = hold_q;
    case (state_q)
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (rise_c) begin
          if (hold_done_c) state_d = ST_RUN;
          else             hold_d  = hold_q + RSTLEN_W'(1);
        end
      end
      default: ;
    endcase
    if (ctrl_ok_c) begin
      if (!new_en_c) begin
        state_d = ST_OFF;
      end else if (state_q == ST_OFF || new_sel_c != sel_q) begin
        state_d  = ST_DRAIN;
        active_d = new_sel_c;
        drain_d  = 1'b0;
      end
    end
  end

  // Pad routing and reset decode from registered state only
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    rst_o  = '1;
    if (state_q == ST_RUN) begin
      for (int unsigned k = 0; k < N_DESIGNS; k++) begin
        if (active_q == SEL_W'(k)) begin
          io_out   = dso_bus[k*IO_W +: IO_W];
          io_oeb   = oeb_bus[k*IO_W +: IO_W];
          rst_o[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_OFF;
      sel_q    <= '0;
      active_q <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      div_q    <= '0;
      rstlen_q <= RSTLEN_W'(RST_DEFAULT);
      hold_q   <= '0;
      drain_q  <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      en_q     <= en_d;
      err_q    <= err_d;
      div_q    <= div_d;
      rstlen_q <= rstlen_d;
      hold_q   <= hold_d;
      drain_q  <= drain_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

endmodule

// File: tb/tb_design_select_ctrl.sv
// Directed self-checking bench for design_select_ctrl.
module tb_design_select_ctrl;

  localparam int N    = 16;
  localparam int IO_W = 28;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0]       wbs_adr_i = '0, wbs_dat_i = '0;
  logic [31:0]       wbs_dat_o;
  logic              wbs_ack_o;
  logic [IO_W-1:0]   io_in = '0;
  logic [IO_W-1:0]   dsi_all;
  logic [N*IO_W-1:0] dso_bus, oeb_bus;
  logic [IO_W-1:0]   io_out, io_oeb;
  logic [N-1:0]      rst_o;
  logic              design_clk_o;

  logic [IO_W-1:0]   dso_pat [N];
  logic [IO_W-1:0]   oeb_pat [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      dso_bus[k*IO_W +: IO_W] = dso_pat[k];
      oeb_bus[k*IO_W +: IO_W] = oeb_pat[k];
    end
  end

  design_select_ctrl dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_ack_o    (wbs_ack_o),
    .io_in        (io_in),
    .dsi_all      (dsi_all),
    .dso_bus      (dso_bus),
    .oeb_bus      (oeb_bus),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .rst_o        (rst_o),
    .design_clk_o (design_clk_o)
  );

  // Bus drivers; called and returning at 1 time unit after a rising edge
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = 1'b1; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) got = 1;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL wb_write_ack adr=%h: ack=0 after 8 cycles, required ack=1", a);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got = 0;
    d = 'x;
    wbs_adr_i = a; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin got = 1; d = wbs_dat_o; end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL wb_read_ack adr=%h: ack=0 after 8 cycles, required ack=1", a);
    end
  endtask

  // Follows a CTRL write that entered DRAIN: rises from edge 3 on fall in HOLD
  task automatic run_check(input int idx, input int nrises, input string name);
    int           rises = 0;
    bit           done  = 0;
    logic         prev  = design_clk_o;
    logic [N-1:0] er;
    logic [IO_W-1:0] eo, ev;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(posedge wb_clk_i); #1;
      if (k >= 3 && design_clk_o && !prev) rises++;
      prev = design_clk_o;
      er = '1; eo = '1; ev = '0;
      if (rises >= nrises) begin
        er[idx] = 1'b0; eo = oeb_pat[idx]; ev = dso_pat[idx]; done = 1;
      end
      n_cmp++;
      if (rst_o !== er || io_oeb !== eo || io_out !== ev) begin
        n_bad++;
        $display("FAIL %s cycle %0d: rst_o=%h io_oeb=%h io_out=%h, required %h %h %h",
                 name, k, rst_o, io_oeb, io_out, er, eo, ev);
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_timeout: rises=%0d, required %0d", name, rises, nrises);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_cmp++;
    if (rst_o !== '1 || io_oeb !== '1 || io_out !== '0 || design_clk_o !== 1'b0 ||
        wbs_ack_o !== 1'b0 || wbs_dat_o !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rst_o=%h io_oeb=%h io_out=%h dclk=%b ack=%b dat=%h, required all-1/all-1/0/0/0/0",
               rst_o, io_oeb, io_out, design_clk_o, wbs_ack_o, wbs_dat_o);
    end
    io_in = 28'h5A5_1234; #1;
    n_cmp++;
    if (dsi_all !== 28'h5A5_1234) begin
      n_bad++; $display("FAIL dsi_passthrough: got %h, required %h", dsi_all, 28'h5A5_1234);
    end
    wb_read(BASE + 32'hC, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h, required 0", d); end
    wb_read(BASE + 32'h0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h, required 0", d); end
    wb_read(BASE + 32'h8, d);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL reset_rstlen: got %h, required 4", d); end
  endtask

  task automatic test_base_mismatch();
    logic [31:0] d;
    int acks = 0;
    wbs_adr_i = BASE + 32'h10; wbs_dat_i = 32'h103; wbs_we_i = 1'b1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    n_cmp++;
    if (acks != 0) begin n_bad++; $display("FAIL base_mismatch_ack: %0d acks, required 0", acks); end
    wb_read(BASE + 32'h0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL base_mismatch_ctrl: got %h, required 0", d); end
  endtask

  task automatic test_select_run();
    logic [31:0] d;
    int per = 0;
    bit seen = 0;
    logic prev;
    wb_write(BASE + 32'h4, 32'h1);
    wb_write(BASE + 32'h8, 32'h3);
    wb_write(BASE + 32'h0, 32'h102);
    run_check(2, 3, "select_run_d2");
    wb_read(BASE + 32'hC, d);
    n_cmp++;
    if (d !== 32'h00B) begin n_bad++; $display("FAIL run_status: got %h, required 00B", d); end
    dso_pat[2] = 28'h0F0_F0F1; #1;
    n_cmp++;
    if (io_out !== 28'h0F0_F0F1) begin
      n_bad++; $display("FAIL run_io_follow: got %h, required %h", io_out, 28'h0F0_F0F1);
    end
    // Measure rise-to-rise spacing of the design clock (DIV=1 -> 4 cycles)
    prev = design_clk_o;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge wb_clk_i); #1;
      if (per > 0) per++;
      if (design_clk_o && !prev) begin
        if (per == 0) per = 1;
        else seen = 1;
      end
      prev = design_clk_o;
    end
    n_cmp++;
    if (!seen || per != 5) begin
      n_bad++; $display("FAIL design_clk_period: got %0d cycles, required 4", per - 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    wbs_adr_i = BASE + 32'h8; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      acks[i] = wbs_ack_o;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    n_cmp++;
    if (acks !== 4'b0101) begin n_bad++; $display("FAIL back_to_back_ack: got %b, required 0101", acks); end
  endtask

  task automatic test_err_sel();
    logic [31:0] d;
    wb_write(BASE + 32'h0, 32'h1FF);
    wb_read(BASE + 32'hC, d);
    n_cmp++;
    if (d !== 32'h40B) begin n_bad++; $display("FAIL err_status: got %h, required 40B", d); end
    n_cmp++;
    if (rst_o !== 16'hFFFB || io_out !== dso_pat[2]) begin
      n_bad++; $display("FAIL err_keeps_run: rst_o=%h io_out=%h, required FFFB %h", rst_o, io_out, dso_pat[2]);
    end
    wb_write(BASE + 32'hC, 32'h0);
    wb_read(BASE + 32'hC, d);
    n_cmp++;
    if (d !== 32'h00B) begin n_bad++; $display("FAIL err_clear: got %h, required 00B", d); end
  endtask

  task automatic test_abort_hold();
    logic [31:0] d;
    wb_write(BASE + 32'h0, 32'h002);
    n_cmp++;
    if (rst_o !== '1) begin n_bad++; $display("FAIL off_before_hold: rst_o=%h, required FFFF", rst_o); end
    wb_write(BASE + 32'h0, 32'h102);
    repeat (3) begin @(posedge wb_clk_i); #1; end
    wb_read(BASE + 32'hC, d);
    n_cmp++;
    if (d !== 32'h00A) begin n_bad++; $display("FAIL mid_hold_status: got %h, required 00A", d); end
    wb_write(BASE + 32'h0, 32'h105);
    run_check(5, 3, "abort_hold_d5");
    wb_read(BASE + 32'hC, d);
    n_cmp++;
    if (d !== 32'h017) begin n_bad++; $display("FAIL abort_status: got %h, required 017", d); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    wb_write(BASE + 32'h0, 32'h005);
    n_cmp++;
    if (rst_o !== '1 || io_oeb !== '1 || io_out !== '0) begin
      n_bad++; $display("FAIL disable_off: rst_o=%h io_oeb=%h io_out=%h, required FFFF all-1 0",
                        rst_o, io_oeb, io_out);
    end
    wb_read(BASE + 32'hC, d);
    n_cmp++;
    if (d[1:0] !== 2'd0) begin n_bad++; $display("FAIL disable_state: got %0d, required 0", d[1:0]); end
    wb_read(BASE + 32'h0, d);
    n_cmp++;
    if (d !== 32'h005) begin n_bad++; $display("FAIL disable_ctrl: got %h, required 005", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wb_write(BASE + 32'h0, 32'h103);
    repeat (4) begin @(posedge wb_clk_i); #1; end
    #1 wb_rst_i = 1'b1;
    #1;
    n_cmp++;
    if (rst_o !== '1 || io_oeb !== '1 || io_out !== '0 || design_clk_o !== 1'b0 ||
        wbs_ack_o !== 1'b0 || wbs_dat_o !== '0) begin
      n_bad++;
      $display("FAIL async_reset: rst_o=%h io_oeb=%h io_out=%h dclk=%b ack=%b dat=%h, required reset values",
               rst_o, io_oeb, io_out, design_clk_o, wbs_ack_o, wbs_dat_o);
    end
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
    wb_read(BASE + 32'h0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL async_ctrl: got %h, required 0", d); end
    wb_read(BASE + 32'h4, d);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL async_clkdiv: got %h, required 0", d); end
    wb_read(BASE + 32'h8, d);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL async_rstlen: got %h, required 4", d); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      dso_pat[k] = IO_W'(32'h0ABC_0000 ^ (k * 32'h0011_1111));
      oeb_pat[k] = IO_W'(~(32'h1 << k));
    end
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    test_reset();
    test_base_mismatch();
    test_select_run();
    test_back_to_back();
    test_err_sel();
    test_abort_hold();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
